// File: rtl/risc_mgmt_claim_arbiter.sv
// Claim arbiter between the RISC-MGMT core and N_EXT ISA extensions: grants one claimer and sequences
// its start/stall/done/kill/timeout handshake. Optional macro: RISC_MGMT_CLAIM_CONFLICT_EN.
module risc_mgmt_claim_arbiter #(
    parameter int  N_EXT          = 4,
    parameter int  TIMEOUT_CYCLES = 256,
    localparam int IDX_W          = (N_EXT > 1) ? $clog2(N_EXT) : 1
) (
    input  logic               CLK,
    input  logic               nRST,
    input  logic               insn_valid,
    input  logic [31:0]        insn,
    input  logic               flush,
    output logic [31:0]        ext_insn,
    input  logic [N_EXT-1:0]   ext_claim,
    input  logic [N_EXT-1:0]   ext_mem_to_reg,
    input  logic [5*N_EXT-1:0] ext_rsel_s_0,
    input  logic [5*N_EXT-1:0] ext_rsel_s_1,
    input  logic [5*N_EXT-1:0] ext_rsel_d,
    input  logic [N_EXT-1:0]   ext_done,
    output logic [N_EXT-1:0]   ext_start,
    output logic [N_EXT-1:0]   ext_kill,
    output logic               claimed,
    output logic [IDX_W-1:0]   grant_idx,
    output logic [4:0]         rsel_s_0,
    output logic [4:0]         rsel_s_1,
    output logic [4:0]         rsel_d,
    output logic               mem_to_reg,
    output logic               stall,
    output logic               retire,
    output logic               timeout,
    output logic               illegal_insn
);

    localparam int               CNT_W      = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam bit               TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [N_EXT-1:0] ONE        = N_EXT'(1);

    typedef enum logic {IDLE, EXEC} state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   grant_q, grant_d;
    logic [4:0]         s0_q, s0_d, s1_q, s1_d, d_q, d_d;
    logic               m2r_q, m2r_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N_EXT-1:0]   start_q, start_d, kill_q, kill_d;
    logic               retire_q, retire_d, timeout_q, timeout_d;

    logic [IDX_W-1:0]   win_idx;
    logic [4:0]         win_s0, win_s1, win_d;
    logic               win_m2r;
    logic               claim_any, conflict, take, done_g, timeout_hit;

    assign ext_insn = insn;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        win_idx = '0;
        win_s0  = '0;
        win_s1  = '0;
        win_d   = '0;
        win_m2r = 1'b0;
        // Walking downward lets the lowest-index claimer overwrite higher ones.
        for (int i = N_EXT - 1; i >= 0; i--) begin
            if (ext_claim[i]) begin
                win_idx = IDX_W'(i);
                win_s0  = ext_rsel_s_0[5*i +: 5];
                win_s1  = ext_rsel_s_1[5*i +: 5];
                win_d   = ext_rsel_d[5*i +: 5];
                win_m2r = ext_mem_to_reg[i];
            end
        end
    end

    assign claim_any = insn_valid & (|ext_claim) & ~flush;
`ifdef RISC_MGMT_CLAIM_CONFLICT_EN
    assign conflict = claim_any & ($countones(ext_claim) > 1);
`else
    assign conflict = 1'b0;
`endif
    assign take        = claim_any & ~conflict;
    assign done_g      = ext_done[grant_q];
    assign timeout_hit = TIMEOUT_EN && (cnt_q == CNT_LAST);

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        s0_d       = s0_q;
        s1_d       = s1_q;
        d_d        = d_q;
        m2r_d      = m2r_q;
        cnt_d      = cnt_q;
        start_d    = '0;
        kill_d     = '0;
        retire_d   = 1'b0;
        timeout_d  = 1'b0;
        claimed    = 1'b0;
        stall      = 1'b0;
        grant_idx  = '0;
        rsel_s_0   = '0;
        rsel_s_1   = '0;
        rsel_d     = '0;
        mem_to_reg = 1'b0;
        unique case (state_q)
            IDLE: begin
                claimed = take;
                if (take) begin
                    grant_idx  = win_idx;
                    rsel_s_0   = win_s0;
                    rsel_s_1   = win_s1;
                    rsel_d     = win_d;
                    mem_to_reg = win_m2r;
                    state_d    = EXEC;
                    grant_d    = win_idx;
                    s0_d       = win_s0;
                    s1_d       = win_s1;
                    d_d        = win_d;
                    m2r_d      = win_m2r;
                    cnt_d      = '0;
                    start_d    = ONE << win_idx;
                end
            end
            EXEC: begin
                claimed    = 1'b1;
                stall      = 1'b1;
                grant_idx  = grant_q;
                rsel_s_0   = s0_q;
                rsel_s_1   = s1_q;
                rsel_d     = d_q;
                mem_to_reg = m2r_q;
                cnt_d      = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
                // Flush outranks a coincident done: the instruction is killed, never retired.
                if (flush) begin
                    kill_d  = ONE << grant_q;
                    state_d = IDLE;
                end else if (done_g) begin
                    stall    = 1'b0;
                    retire_d = 1'b1;
                    state_d  = IDLE;
                end else if (timeout_hit) begin
                    kill_d    = ONE << grant_q;
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            s0_q      <= '0;
            s1_q      <= '0;
            d_q       <= '0;
            m2r_q     <= 1'b0;
            cnt_q     <= '0;
            start_q   <= '0;
            kill_q    <= '0;
            retire_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            s0_q      <= s0_d;
            s1_q      <= s1_d;
            d_q       <= d_d;
            m2r_q     <= m2r_d;
            cnt_q     <= cnt_d;
            start_q   <= start_d;
            kill_q    <= kill_d;
            retire_q  <= retire_d;
            timeout_q <= timeout_d;
        end
    end

`ifdef RISC_MGMT_CLAIM_CONFLICT_EN
    logic illegal_q;
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) illegal_q <= 1'b0;
        else       illegal_q <= (state_q == IDLE) & conflict;
    end
    assign illegal_insn = illegal_q;
`else
    assign illegal_insn = 1'b0;
`endif

    assign ext_start = start_q;
    assign ext_kill  = kill_q;
    assign retire    = retire_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_risc_mgmt_claim_arbiter.sv
// Self-checking bench for risc_mgmt_claim_arbiter: directed scenarios plus randomized transactions
// checked against a per-transaction timeline model (winner, latency, expected pulses).
module tb_risc_mgmt_claim_arbiter;
    localparam int N  = 4;
    localparam int TO = 8;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        insn_valid, flush;
    logic [31:0] insn, ext_insn;
    logic [3:0]  ext_claim, ext_mem_to_reg, ext_done, ext_start, ext_kill;
    logic [19:0] ext_rsel_s_0, ext_rsel_s_1, ext_rsel_d;
    logic        claimed, mem_to_reg, stall, retire, timeout, illegal_insn;
    logic [1:0]  grant_idx;
    logic [4:0]  rsel_s_0, rsel_s_1, rsel_d;

    logic [4:0]  f_s0 [N];
    logic [4:0]  f_s1 [N];
    logic [4:0]  f_d  [N];
    logic        f_m2r[N];

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    risc_mgmt_claim_arbiter #(.N_EXT(N), .TIMEOUT_CYCLES(TO)) dut (
        .CLK(CLK), .nRST(nRST), .insn_valid(insn_valid), .insn(insn), .flush(flush),
        .ext_insn(ext_insn), .ext_claim(ext_claim), .ext_mem_to_reg(ext_mem_to_reg),
        .ext_rsel_s_0(ext_rsel_s_0), .ext_rsel_s_1(ext_rsel_s_1), .ext_rsel_d(ext_rsel_d),
        .ext_done(ext_done), .ext_start(ext_start), .ext_kill(ext_kill), .claimed(claimed),
        .grant_idx(grant_idx), .rsel_s_0(rsel_s_0), .rsel_s_1(rsel_s_1), .rsel_d(rsel_d),
        .mem_to_reg(mem_to_reg), .stall(stall), .retire(retire), .timeout(timeout),
        .illegal_insn(illegal_insn)
    );

    logic [30:0] obs;
    assign obs = {claimed, stall, grant_idx, rsel_s_0, rsel_s_1, rsel_d, mem_to_reg,
                  ext_start, ext_kill, retire, timeout, illegal_insn};

    function automatic logic [30:0] ev(bit cl, bit st, int idx, logic [4:0] a, logic [4:0] b,
                                       logic [4:0] c, bit m, logic [3:0] s, logic [3:0] k,
                                       bit r, bit t, bit il);
        return {cl, st, 2'(idx), a, b, c, m, s, k, r, t, il};
    endfunction

    // Expected view while extension i owns the pipeline (fields stable in directed tests).
    function automatic logic [30:0] eg(int i, bit st, logic [3:0] s);
        return ev(1'b1, st, i, f_s0[i], f_s1[i], f_d[i], f_m2r[i], s, 4'd0, 1'b0, 1'b0, 1'b0);
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        insn_valid = 1'b0;
        insn       = '0;
        flush      = 1'b0;
        ext_claim  = '0;
        ext_done   = '0;
    endtask

    task automatic drive_fields();
        for (int i = 0; i < N; i++) begin
            ext_rsel_s_0[5*i +: 5] = f_s0[i];
            ext_rsel_s_1[5*i +: 5] = f_s1[i];
            ext_rsel_d[5*i +: 5]   = f_d[i];
            ext_mem_to_reg[i]      = f_m2r[i];
        end
    endtask

    task automatic rand_fields();
        for (int i = 0; i < N; i++) begin
            f_s0[i]  = 5'($urandom);
            f_s1[i]  = 5'($urandom);
            f_d[i]   = 5'($urandom);
            f_m2r[i] = 1'($urandom);
        end
        drive_fields();
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        idle_inputs();
        rand_fields();
        repeat (2) @(posedge CLK);
        #1;
        checks++;
        if (obs !== 31'd0) begin errors++; $display("FAIL reset_held: got %h want %h", obs, 31'd0); end
        nRST = 1'b1;
        #1;
        checks++;
        if (obs !== 31'd0) begin errors++; $display("FAIL reset_release: got %h want %h", obs, 31'd0); end
        tick();
    endtask

    task automatic test_single();
        for (int i = 0; i < N; i++) begin f_s0[i] = '0; f_s1[i] = '0; f_d[i] = '0; f_m2r[i] = 1'b0; end
        f_d[2] = 5'd7;
        drive_fields();
        insn = 32'h0000_002B; insn_valid = 1'b1; ext_claim = 4'b0100;
        #1;
        checks++;
        if (obs !== eg(2, 1'b0, 4'd0)) begin errors++; $display("FAIL single_claim: got %h want %h", obs, eg(2, 1'b0, 4'd0)); end
        checks++;
        if (ext_insn !== 32'h0000_002B) begin errors++; $display("FAIL single_bcast: got %h want %h", ext_insn, 32'h2B); end
        tick();
        idle_inputs();
        for (int k = 0; k < 4; k++) begin
            ext_done = (k == 3) ? 4'b0100 : 4'b0000;
            #1;
            checks++;
            if (obs !== eg(2, k != 3, (k == 0) ? 4'b0100 : 4'b0000)) begin
                errors++; $display("FAIL single_exec%0d: got %h want %h", k, obs, eg(2, k != 3, (k == 0) ? 4'b0100 : 4'b0000));
            end
            tick();
        end
        ext_done = '0;
        #1;
        checks++;
        if (obs !== ev(0, 0, 0, 0, 0, 0, 0, 4'd0, 4'd0, 1, 0, 0)) begin errors++; $display("FAIL single_retire: got %h", obs); end
        tick();
        #1;
        checks++;
        if (obs !== 31'd0) begin errors++; $display("FAIL single_after: got %h want 0", obs); end
    endtask

    task automatic test_multi();
        rand_fields();
        insn = $urandom; insn_valid = 1'b1; ext_claim = 4'b0110;
        #1;
`ifdef RISC_MGMT_CLAIM_CONFLICT_EN
        checks++;
        if (obs !== 31'd0) begin errors++; $display("FAIL multi_noclaim: got %h want 0", obs); end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (obs !== ev(0, 0, 0, 0, 0, 0, 0, 4'd0, 4'd0, 0, 0, 1)) begin errors++; $display("FAIL multi_illegal: got %h", obs); end
        tick();
        #1;
        checks++;
        if (obs !== 31'd0) begin errors++; $display("FAIL multi_after: got %h want 0", obs); end
`else
        checks++;
        if (obs !== eg(1, 1'b0, 4'd0)) begin errors++; $display("FAIL multi_winner: got %h want %h", obs, eg(1, 1'b0, 4'd0)); end
        tick();
        idle_inputs();
        ext_done = 4'b0010;
        #1;
        checks++;
        if (obs !== eg(1, 1'b0, 4'b0010)) begin errors++; $display("FAIL multi_start_done: got %h want %h", obs, eg(1, 1'b0, 4'b0010)); end
        tick();
        ext_done = '0;
        #1;
        checks++;
        if (obs !== ev(0, 0, 0, 0, 0, 0, 0, 4'd0, 4'd0, 1, 0, 0)) begin errors++; $display("FAIL multi_retire: got %h", obs); end
`endif
        tick();
    endtask

    task automatic test_flush();
        rand_fields();
        insn_valid = 1'b1; ext_claim = 4'b0001; flush = 1'b1;
        #1;
        checks++;
        if (obs !== 31'd0) begin errors++; $display("FAIL flush_idle_claim: got %h want 0", obs); end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (obs !== 31'd0) begin errors++; $display("FAIL flush_idle_nostart: got %h want 0", obs); end
        insn_valid = 1'b1; ext_claim = 4'b0010;
        #1;
        tick();
        idle_inputs();
        for (int k = 0; k < 3; k++) begin
            if (k == 2) begin
                flush = 1'b1; ext_done = 4'b0010;
            end else begin
                #1;
                checks++;
                if (obs !== eg(1, 1'b1, (k == 0) ? 4'b0010 : 4'b0000)) begin errors++; $display("FAIL flush_exec%0d: got %h", k, obs); end
            end
            tick();
        end
        idle_inputs();
        #1;
        checks++;
        if (obs !== ev(0, 0, 0, 0, 0, 0, 0, 4'd0, 4'b0010, 0, 0, 0)) begin errors++; $display("FAIL flush_kill: got %h", obs); end
        tick();
        #1;
        checks++;
        if (obs !== 31'd0) begin errors++; $display("FAIL flush_after: got %h want 0", obs); end
    endtask

    task automatic test_timeout();
        rand_fields();
        insn_valid = 1'b1; ext_claim = 4'b1000;
        tick();
        idle_inputs();
        for (int k = 0; k < TO; k++) begin
            #1;
            checks++;
            if (obs !== eg(3, 1'b1, (k == 0) ? 4'b1000 : 4'b0000)) begin errors++; $display("FAIL timeout_exec%0d: got %h", k, obs); end
            tick();
        end
        #1;
        checks++;
        if (obs !== ev(0, 0, 0, 0, 0, 0, 0, 4'd0, 4'b1000, 0, 1, 0)) begin errors++; $display("FAIL timeout_pulse: got %h", obs); end
        tick();
        #1;
        checks++;
        if (obs !== 31'd0) begin errors++; $display("FAIL timeout_after: got %h want 0", obs); end
    endtask

    task automatic test_back_to_back();
        rand_fields();
        insn_valid = 1'b1; ext_claim = 4'b1000;
        tick();
        idle_inputs();
        for (int k = 0; k < 3; k++) begin
            ext_done = (k == 1) ? 4'b0001 : (k == 2) ? 4'b1000 : 4'b0000;
            #1;
            checks++;
            if (obs !== eg(3, k != 2, (k == 0) ? 4'b1000 : 4'b0000)) begin errors++; $display("FAIL b2b_exec%0d: got %h", k, obs); end
            tick();
        end
        idle_inputs();
        insn_valid = 1'b1; ext_claim = 4'b0001;
        #1;
        checks++;
        if (obs !== ev(1, 0, 0, f_s0[0], f_s1[0], f_d[0], f_m2r[0], 4'd0, 4'd0, 1, 0, 0)) begin
            errors++; $display("FAIL b2b_reclaim: got %h", obs);
        end
        tick();
        idle_inputs();
        ext_done = 4'b0001;
        #1;
        checks++;
        if (obs !== eg(0, 1'b0, 4'b0001)) begin errors++; $display("FAIL b2b_second: got %h", obs); end
        tick();
        ext_done = 4'b1111;
        #1;
        checks++;
        if (obs !== ev(0, 0, 0, 0, 0, 0, 0, 4'd0, 4'd0, 1, 0, 0)) begin errors++; $display("FAIL b2b_retire2: got %h", obs); end
        tick();
        ext_done = '0;
        #1;
        checks++;
        if (obs !== 31'd0) begin errors++; $display("FAIL idle_done_ignored: got %h want 0", obs); end
        tick();
    endtask

    task automatic test_reset_mid_exec();
        rand_fields();
        insn_valid = 1'b1; ext_claim = 4'b0100;
        tick();
        idle_inputs();
        repeat (3) tick();
        nRST = 1'b0;
        #1;
        checks++;
        if (obs !== 31'd0) begin errors++; $display("FAIL rst_mid_async: got %h want 0", obs); end
        tick();
        nRST = 1'b1;
        #1;
        tick();
        #1;
        checks++;
        if (obs !== 31'd0) begin errors++; $display("FAIL rst_mid_after: got %h want 0", obs); end
        tick();
    endtask

    task automatic test_random();
        bit         pend_ret = 1'b0;
        logic [3:0] claims, oh;
        int         w, lat;
        logic [4:0] ls0, ls1, ld;
        bit         lm;
        logic [31:0] insn_r;
        for (int t = 0; t < 40; t++) begin
            rand_fields();
`ifdef RISC_MGMT_CLAIM_CONFLICT_EN
            claims = 4'b0001 << $urandom_range(0, 3);
`else
            claims = 4'($urandom_range(1, 15));
`endif
            w = 0;
            for (int i = N - 1; i >= 0; i--) if (claims[i]) w = i;
            oh  = 4'b0001 << w;
            lat = $urandom_range(0, TO - 1);
            ls0 = f_s0[w]; ls1 = f_s1[w]; ld = f_d[w]; lm = f_m2r[w];
            insn_r = $urandom;
            insn = insn_r; insn_valid = 1'b1; flush = 1'b0; ext_claim = claims; ext_done = 4'($urandom);
            #1;
            checks++;
            if (obs !== ev(1, 0, w, ls0, ls1, ld, lm, 4'd0, 4'd0, pend_ret, 0, 0)) begin
                errors++; $display("FAIL rand%0d_claim: got %h want %h", t, obs, ev(1, 0, w, ls0, ls1, ld, lm, 4'd0, 4'd0, pend_ret, 0, 0));
            end
            checks++;
            if (ext_insn !== insn_r) begin errors++; $display("FAIL rand%0d_bcast: got %h want %h", t, ext_insn, insn_r); end
            tick();
            for (int k = 0; k <= lat; k++) begin
                rand_fields();
                insn = $urandom; insn_valid = 1'($urandom); ext_claim = 4'($urandom);
                ext_done = (4'($urandom) & ~oh) | ((k == lat) ? oh : 4'd0);
                #1;
                checks++;
                if (obs !== ev(1, k != lat, w, ls0, ls1, ld, lm, (k == 0) ? oh : 4'd0, 4'd0, 0, 0, 0)) begin
                    errors++; $display("FAIL rand%0d_exec%0d: got %h want %h", t, k, obs, ev(1, k != lat, w, ls0, ls1, ld, lm, (k == 0) ? oh : 4'd0, 4'd0, 0, 0, 0));
                end
                tick();
            end
            pend_ret = 1'b1;
            if ($urandom_range(0, 1) == 1) begin
                idle_inputs();
                #1;
                checks++;
                if (obs !== ev(0, 0, 0, 0, 0, 0, 0, 4'd0, 4'd0, 1, 0, 0)) begin errors++; $display("FAIL rand%0d_retire: got %h", t, obs); end
                tick();
                pend_ret = 1'b0;
            end
        end
        idle_inputs();
        #1;
        checks++;
        if (obs !== ev(0, 0, 0, 0, 0, 0, 0, 4'd0, 4'd0, pend_ret, 0, 0)) begin errors++; $display("FAIL rand_final: got %h", obs); end
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi();
        test_flush();
        test_timeout();
        test_back_to_back();
        test_reset_mid_exec();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
